// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Stimulus/capture stage for a combinational boolean-expression block.
//   On an accepted start it drives every input vector in ascending order,
//   holds each for HOLD_CYCLES clocks, samples F at the end of each hold
//   window into table_out, and on completion pulses done and reports whether
//   the captured table equals the expected table latched at start.
//
// Parameters:
//   N_IN        number of expression inputs (1..6); sweep covers 2**N_IN vectors
//   HOLD_CYCLES clocks each vector is held before F is sampled (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle sweep request, ignored unless idle
//   expected   expected truth table (bit i = F for vector i), latched on start
//   f_in       F from the expression block
//   vec_out    drive to expression inputs (MSB = A)
//   busy       high while a sweep is running
//   done       one-cycle completion pulse
//   pass       captured table == latched expected; valid from done to next start
//   table_out  captured truth table
//
// Optional feature (macro TTS_FIRST_FAIL_EN):
//   adds fail_valid / first_fail reporting the first vector whose captured
//   F differs from the latched expected table.

module truth_table_sweeper #(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   f_in,
  output logic [N_IN-1:0]        vec_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   table_out
`ifdef TTS_FIRST_FAIL_EN
  ,
  output logic                   fail_valid,
  output logic [N_IN-1:0]        first_fail
`endif
);

  localparam int NVEC = 1 << N_IN;
  localparam int HW   = $clog2(HOLD_CYCLES) + 1;
  localparam int IW   = N_IN + 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NVEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NVEC-1:0]   table_q, table_d;
  logic [NVEC-1:0]   exp_q, exp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic              start_ok_s;
  logic              sample_s;
  logic              last_s;
  logic [NVEC-1:0]   captured_s;

  assign start_ok_s = (state_q == S_IDLE) && start;
  assign sample_s   = (state_q == S_DRIVE) && (hold_q == HOLD_LAST);
  assign last_s     = sample_s && (idx_q == IDX_LAST);

  // Table as it will look after this edge's sample; used for the final
  // compare so the bit being captured right now is included.
  always_comb begin
    captured_s = table_q;
    captured_s[idx_q[N_IN-1:0]] = f_in;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRIVE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: hold counter, vector index, capture and verdict.
  always_comb begin
    hold_d  = hold_q;
    idx_d   = idx_q;
    table_d = table_q;
    exp_d   = exp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok_s) begin
          hold_d  = {HW{1'b0}};
          idx_d   = {IW{1'b0}};
          table_d = {NVEC{1'b0}};
          exp_d   = expected;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        if (sample_s) begin
          table_d = captured_s;
          hold_d  = {HW{1'b0}};
          if (last_s) begin
            idx_d  = {IW{1'b0}};
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (captured_s == exp_q);
          end else begin
            idx_d  = idx_q + IW'(1);
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
      default: begin
        hold_d  = {HW{1'b0}};
        idx_d   = {IW{1'b0}};
        table_d = {NVEC{1'b0}};
        busy_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= {HW{1'b0}};
      idx_q   <= {IW{1'b0}};
      table_q <= {NVEC{1'b0}};
      exp_q   <= {NVEC{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Output mapping; every output comes straight from a flop.
  always_comb begin
    vec_out   = idx_q[N_IN-1:0];
    busy      = busy_q;
    done      = done_q;
    pass      = pass_q;
    table_out = table_q;
  end

`ifdef TTS_FIRST_FAIL_EN
  logic              fail_valid_q, fail_valid_d;
  logic [N_IN-1:0]   first_fail_q, first_fail_d;

  // First-mismatch capture; later mismatches leave the record alone.
  always_comb begin
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    if (start_ok_s) begin
      fail_valid_d = 1'b0;
      first_fail_d = {N_IN{1'b0}};
    end else if (sample_s && !fail_valid_q && (f_in != exp_q[idx_q[N_IN-1:0]])) begin
      fail_valid_d = 1'b1;
      first_fail_d = idx_q[N_IN-1:0];
    end else begin
      fail_valid_d = fail_valid_q;
      first_fail_d = first_fail_q;
    end
  end

  // First-mismatch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid_q <= 1'b0;
      first_fail_q <= {N_IN{1'b0}};
    end else begin
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
    end
  end

  // First-mismatch outputs.
  always_comb begin
    fail_valid = fail_valid_q;
    first_fail = first_fail_q;
  end
`endif

endmodule
